switch_input_arbiter: RTL



---
 rtl/switch_pkg.sv | 22 ++
 rtl/switch_input_arbiter_if.sv | 29 ++
 rtl/rr_priority_pick.sv | 33 +++
 rtl/switch_input_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared types and sizing helpers for the switch input path
package switch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    function automatic int bus_size(input int data_size, input int addr_size);
        return data_size + addr_size + 1;
    endfunction

    // Local port sits after all neighbour links.
    function automatic int local_port(input int ports_num);
        return ports_num;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_input_arbiter_if.sv
// rtl/switch_input_arbiter_if.sv - input ports to flit queue arbitration bundle
interface switch_input_arbiter_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4,
    parameter int PORTS_NUM = 4
);
    localparam int N        = PORTS_NUM + 1;
    localparam int BUS_SIZE = switch_pkg::bus_size(DATA_SIZE, ADDR_SIZE);
    localparam int IW       = switch_pkg::idx_width(N);

    logic [N-1:0]          req_i;
    logic [BUS_SIZE*N-1:0] data_i;
    logic                  q_full_i;
    logic [N-1:0]          ack_o;
    logic                  wr_req_o;
    logic [BUS_SIZE-1:0]   data_o;
    logic [IW-1:0]         owner_o;

    modport master (
        output req_i, data_i, q_full_i,
        input  ack_o, wr_req_o, data_o, owner_o
    );

    modport slave (
        input  req_i, data_i, q_full_i,
        output ack_o, wr_req_o, data_o, owner_o
    );

endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - first requester at or after a start index, wrapping modulo N
module rr_priority_pick
    import switch_pkg::*;
#(
    parameter int N  = 5,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] cur;

    // N need not be a power of two, so the wrap is an explicit compare.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cur     = start_i;
        for (int i = 0; i < N; i++) begin
            if (!valid_o && req_i[cur]) begin
                valid_o      = 1'b1;
                grant_o[cur] = 1'b1;
                idx_o        = cur;
            end
            cur = (cur == IW'(N - 1)) ? '0 : cur + 1'b1;
        end
    end

endmodule

// File: rtl/switch_input_arbiter.sv
// rtl/switch_input_arbiter.sv - round-robin input arbiter with burst locking
module switch_input_arbiter
    import switch_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4,
    parameter int PORTS_NUM = 4,
    parameter int MAX_BURST = 4
) (
    input logic                  clk,
    input logic                  a_rst,
    switch_input_arbiter_if.slave bus
);

    localparam int N        = PORTS_NUM + 1;
    localparam int BUS_SIZE = bus_size(DATA_SIZE, ADDR_SIZE);
    localparam int IW       = idx_width(N);
    localparam int BW       = idx_width(MAX_BURST + 1);

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [BW-1:0]       burst_q, burst_d;
    logic [N-1:0]        ack_q, ack_d;
    logic                wr_q, wr_d;
    logic [BUS_SIZE-1:0] data_q, data_d;

    logic [IW-1:0]       owner_inc;
    logic [IW-1:0]       pick_start;
    logic [N-1:0]        pick_grant;
    logic [IW-1:0]       pick_idx;
    logic                pick_valid;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == IW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    assign owner_inc  = wrap_inc(owner_q);
    assign pick_start = (state_q == LOCK) ? owner_inc : ptr_q;

    rr_priority_pick #(.N(N), .IW(IW)) u_pick (
        .req_i   (bus.req_i),
        .start_i (pick_start),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        ack_d   = '0;
        wr_d    = 1'b0;
        data_d  = data_q;

        // A full queue freezes everything, including a pending release.
        if (!bus.q_full_i) begin
            if (state_q == LOCK && bus.req_i[owner_q] && burst_q < BW'(MAX_BURST)) begin
                ack_d[owner_q] = 1'b1;
                burst_d        = burst_q + 1'b1;
            end else begin
                if (state_q == LOCK) begin
                    ptr_d = owner_inc;
                end
                if (pick_valid) begin
                    ack_d   = pick_grant;
                    owner_d = pick_idx;
                    burst_d = BW'(1);
                    if (MAX_BURST == 1) begin
                        state_d = IDLE;
                        ptr_d   = wrap_inc(pick_idx);
                    end else begin
                        state_d = LOCK;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        end

        wr_d = |ack_d;
        for (int k = 0; k < N; k++) begin
            if (ack_d[k]) begin
                data_d = bus.data_i[k*BUS_SIZE +: BUS_SIZE];
            end
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            ack_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            ack_q   <= ack_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

    assign bus.ack_o    = ack_q;
    assign bus.wr_req_o = wr_q;
    assign bus.data_o   = data_q;
    assign bus.owner_o  = owner_q;

endmodule
